// File: rtl/data_inf_rx_packer.sv
// Packs NUM narrow beats (lane 0 first) into one registered word with keep mask; s_last flushes a partial word.
// Word valid one cycle after the completing beat; beats stall only while a word is held and m_ready is low.
module data_inf_rx_packer #(
  parameter int DSIZE = 8,
  parameter int NUM   = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DSIZE-1:0]       s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DSIZE*NUM-1:0]   m_data,
  output logic [NUM-1:0]         m_keep,
  output logic                   m_last,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt, cur_idx;
  logic [DSIZE*NUM-1:0]   acc, acc_nxt, merged;
  logic [NUM-1:0]         keep_nxt;
  logic                   beat_take, word_take, complete;

  assign s_ready   = !m_valid || m_ready;
  assign beat_take = s_valid && s_ready;
  assign word_take = m_valid && m_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    acc_nxt   = acc;
    // IDLE always fills lane 0, regardless of any stale index
    cur_idx   = (state == IDLE) ? '0 : idx;
    merged    = acc;
    merged[cur_idx*DSIZE +: DSIZE] = s_data;
    keep_nxt  = '0;
    for (int i = 0; i < NUM; i++) begin
      keep_nxt[i] = (IDX_W'(i) <= cur_idx);
    end
    complete  = beat_take && (s_last || (cur_idx == LAST_IDX));
    if (beat_take) begin
      if (complete) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        acc_nxt   = '0;
      end else begin
        state_nxt = FILL;
        idx_nxt   = cur_idx + IDX_W'(1);
        acc_nxt   = merged;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      acc   <= acc_nxt;
    end
  end

  // A completing beat may reload the output in the same edge the old word leaves
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_last    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (complete) begin
        m_valid <= 1'b1;
        m_data  <= merged;
        m_keep  <= keep_nxt;
        m_last  <= s_last;
      end else if (word_take) begin
        m_valid <= 1'b0;
      end
      if (word_take && m_last) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_inf_rx_packer.sv
// Directed bench for data_inf_rx_packer (NUM=4, CNT_W=4 so the frame counter wraps quickly).
module tb_data_inf_rx_packer;

  localparam int DSIZE = 8;
  localparam int NUM   = 4;
  localparam int CNT_W = 4;

  logic                 clock = 1'b0;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic [DSIZE-1:0]     s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [DSIZE*NUM-1:0] m_data;
  logic [NUM-1:0]       m_keep;
  logic                 m_last;
  logic [CNT_W-1:0]     frame_cnt;

  int total = 0;
  int bad   = 0;
  int stalls;

  data_inf_rx_packer #(.DSIZE(DSIZE), .NUM(NUM), .CNT_W(CNT_W)) u_dut (
    .clock     (clock),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
    .frame_cnt (frame_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one beat and hold it until accepted; leaves s_valid asserted on return.
  task automatic send(input logic [DSIZE-1:0] d, input logic l);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    while (!s_ready && n < 50) begin
      stalls++;
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    step();
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    stalls  = 0;
    #12;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data",  64'(m_data),  64'd0);
    chk("rst_m_keep",  64'(m_keep),  64'd0);
    chk("rst_cnt",     64'(frame_cnt), 64'd0);
    @(posedge clock);
    #1 rst = 1'b0;
    step();

    // 1: full word, not end of frame
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    chk("t1_no_early_valid", 64'(m_valid), 64'd0);
    send(8'h44, 1'b0);
    idle();
    chk("t1_valid", 64'(m_valid), 64'd1);
    chk("t1_data",  64'(m_data),  64'h44332211);
    chk("t1_keep",  64'(m_keep),  64'hF);
    chk("t1_last",  64'(m_last),  64'd0);
    step();
    chk("t1_valid_one_cycle", 64'(m_valid), 64'd0);

    // 2: short frame flushes a partial word
    send(8'hA1, 1'b0); send(8'hA2, 1'b1);
    idle();
    chk("t2_data", 64'(m_data), 64'h0000A2A1);
    chk("t2_keep", 64'(m_keep), 64'h3);
    chk("t2_last", 64'(m_last), 64'd1);
    chk("t2_cnt_before", 64'(frame_cnt), 64'd0);
    step();
    chk("t2_cnt_after", 64'(frame_cnt), 64'd1);
    chk("t2_valid_done", 64'(m_valid), 64'd0);

    // 3: backpressure holds the word and stalls input
    m_ready = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    s_data = 8'h99;
    for (int i = 0; i < 5; i++) begin
      chk("t3_s_ready_low", 64'(s_ready), 64'd0);
      chk("t3_hold_data",   64'(m_data),  64'h04030201);
      chk("t3_hold_valid",  64'(m_valid), 64'd1);
      step();
    end
    m_ready = 1'b1;
    #1;
    chk("t3_s_ready_release", 64'(s_ready), 64'd1);
    step();
    idle();
    chk("t3_taken", 64'(m_valid), 64'd0);

    // 4: reset mid-word discards held lanes (0x99 already held, add one more)
    send(8'hAA, 1'b0);
    idle();
    #1 rst = 1'b1;
    #1;
    chk("t4_rst_data", 64'(m_data),    64'd0);
    chk("t4_rst_cnt",  64'(frame_cnt), 64'd0);
    chk("t4_rst_keep", 64'(m_keep),    64'd0);
    step();
    rst = 1'b0;
    step();
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
    idle();
    chk("t4_data", 64'(m_data), 64'h88776655);
    chk("t4_keep", 64'(m_keep), 64'hF);
    step();

    // 5: sixteen single-beat frames wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      send(8'(i + 1), 1'b1);
      chk("t5_keep", 64'(m_keep),    64'h1);
      chk("t5_data", 64'(m_data),    64'(i + 1));
      chk("t5_cnt",  64'(frame_cnt), 64'(i));
    end
    idle();
    step();
    chk("t5_wrap", 64'(frame_cnt), 64'd0);

    // 6: continuous stream, three back-to-back words
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      send(8'(8'h10 + i), 1'b0);
      if (i == 3)  chk("t6_word0", 64'(m_data), 64'h13121110);
      if (i == 4)  chk("t6_gap",   64'(m_valid), 64'd0);
      if (i == 7)  chk("t6_word1", 64'(m_data), 64'h17161514);
      if (i == 11) chk("t6_word2", 64'(m_data), 64'h1B1A1918);
      if (i == 11) chk("t6_valid", 64'(m_valid), 64'd1);
    end
    idle();
    chk("t6_no_stall", 64'(stalls), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
